// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 encryption controller.
// The FSM state enum is shared so that datapath-side code can decode it too.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FINAL,
    DONE
  } type_fsm_state;

  localparam logic [3:0] ROUND_A_START = 4'd0;
  localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage

// File: rtl/round_counter.sv
// Permutation round index: loads the p^12 or p^6 start value, otherwise
// advances by one per enabled cycle. Loads take priority over increment.
module round_counter
  import ascon_pack::*;
#(
  parameter int ROUND_B_START = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       init_a_i,
  input  logic       init_b_i,
  input  logic       en_i,
  output logic [3:0] round_o
);

  localparam logic [3:0] ROUND_B = 4'(ROUND_B_START);

  logic [3:0] round_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      round_q <= 4'd0;
    end else if (init_a_i) begin
      round_q <= ROUND_A_START;
    end else if (init_b_i) begin
      round_q <= ROUND_B;
    end else if (en_i) begin
      round_q <= round_q + 4'd1;
    end
  end

  assign round_o = round_q;

endmodule

// File: rtl/ascon_fsm.sv
// Moore controller sequencing one ASCON-128 encryption (init, one AD block,
// NB_PT_BLOCKS plaintext blocks with the last one absorbed in finalisation).
module ascon_fsm
  import ascon_pack::*;
#(
  parameter int NB_PT_BLOCKS  = 4,
  parameter int ROUND_B_START = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic [3:0] round_o,
  output logic       init_state_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       data_ready_o,
  output logic       end_o
);

  localparam int              BLK_W    = $clog2(NB_PT_BLOCKS) + 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NB_PT_BLOCKS - 1);
  localparam logic [3:0]      ROUND_B  = 4'(ROUND_B_START);

  type_fsm_state    state_q, state_d;
  logic [BLK_W-1:0] blk_q;
  logic [3:0]       round_w;
  logic             init_a, init_b, blk_clr, blk_inc;
  logic             perm, last, cnt_en;

  assign perm = (state_q == INIT) || (state_q == AD) ||
                (state_q == PT)   || (state_q == FINAL);
  assign last = (round_w == ROUND_LAST);
  // Hold at the last round so WAIT/DONE states show 11 rather than 12.
  assign cnt_en = perm && !last;

  round_counter #(
    .ROUND_B_START(ROUND_B_START)
  ) u_round_counter (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .init_a_i (init_a),
    .init_b_i (init_b),
    .en_i     (cnt_en),
    .round_o  (round_w)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      if (blk_clr) begin
        blk_q <= '0;
      end else if (blk_inc) begin
        blk_q <= blk_q + BLK_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    init_a  = 1'b0;
    init_b  = 1'b0;
    blk_clr = 1'b0;
    blk_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = INIT;
          init_a  = 1'b1;
        end
      end
      INIT: begin
        if (last) state_d = WAIT_AD;
      end
      WAIT_AD: begin
        if (data_valid_i) begin
          state_d = AD;
          init_b  = 1'b1;
        end
      end
      AD: begin
        if (last) begin
          state_d = WAIT_PT;
          blk_clr = 1'b1;
        end
      end
      WAIT_PT: begin
        if (data_valid_i) begin
          if (blk_q < BLK_LAST) begin
            state_d = PT;
            init_b  = 1'b1;
          end else begin
            state_d = FINAL;
            init_a  = 1'b1;
          end
        end
      end
      PT: begin
        if (last) begin
          state_d = WAIT_PT;
          blk_inc = 1'b1;
        end
      end
      FINAL: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start_i) begin
          state_d = INIT;
          init_a  = 1'b1;
          blk_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath enables decode from registered state and round only.
  always_comb begin
    init_state_o     = 1'b0;
    en_reg_state_o   = perm;
    en_xor_data_o    = 1'b0;
    en_xor_key_o     = 1'b0;
    en_xor_key_end_o = 1'b0;
    en_xor_lsb_o     = 1'b0;
    en_cipher_o      = 1'b0;
    en_tag_o         = 1'b0;
    data_ready_o     = 1'b0;
    end_o            = 1'b0;
    case (state_q)
      INIT: begin
        init_state_o     = (round_w == ROUND_A_START);
        en_xor_key_end_o = last;
      end
      WAIT_AD, WAIT_PT: begin
        data_ready_o = 1'b1;
      end
      AD: begin
        en_xor_data_o = (round_w == ROUND_B);
        en_xor_lsb_o  = last;
      end
      PT: begin
        en_xor_data_o = (round_w == ROUND_B);
        en_cipher_o   = (round_w == ROUND_B);
      end
      FINAL: begin
        en_xor_data_o    = (round_w == ROUND_A_START);
        en_cipher_o      = (round_w == ROUND_A_START);
        en_xor_key_o     = (round_w == ROUND_A_START);
        en_xor_key_end_o = last;
        en_tag_o         = last;
      end
      DONE: begin
        end_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign round_o = round_w;

endmodule
